// File: rtl/face_threshold_probe.sv
// Decision stage: accepts a candidate window, checks its score against MAX_THR, then probes
// up to NUM_PROBE output-map cells around the centre. Optional hit counter under FACE_CNT_EN.
module face_threshold_probe #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 13,
   parameter int                IMG_W      = 81,
   parameter int                CENTER_OFS = 162,
   parameter logic [DATA_W-1:0] MAX_THR    = 32'h04199999,
   parameter logic [DATA_W-1:0] OM_THR     = 32'h0011EB85,
   parameter int                NUM_PROBE  = 4,
   parameter int                RD_LAT     = 1
) (
   input  logic              iClk,
   input  logic              iReset_n,
   input  logic              iInput_ready,
   input  logic [ADDR_W-1:0] iPosition,
   input  logic [DATA_W-1:0] iMax_val,
   input  logic              iFinish,
   input  logic [DATA_W-1:0] iData_from_OM,
   output logic [ADDR_W-1:0] oAddr_OM,
   output logic              oReady,
   output logic [ADDR_W-1:0] oPosition,
   output logic              oHit,
   output logic              oOutput_ready,
   output logic              oEnd
`ifdef FACE_CNT_EN
   ,output logic [15:0]      oFace_cnt
`endif
);

   localparam int                CNT_W      = $clog2(NUM_PROBE + 1);
   localparam int                LAST_K_I   = NUM_PROBE - 1;
   localparam logic [CNT_W-1:0]  LAST_K     = LAST_K_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0]  ONE_K      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]        LAT_C      = RD_LAT[1:0];
   localparam logic [ADDR_W-1:0] CTR_OFS_C  = CENTER_OFS[ADDR_W-1:0];

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PROBE = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   pos_q, pos_d;
   logic                hit_q, hit_d;
   logic                out_rdy_q, out_rdy_d;
   logic                end_q, end_d;
   logic [CNT_W-1:0]    issue_q, issue_d;
   logic [CNT_W-1:0]    cmp_q, cmp_d;
   logic [1:0]          lat_q, lat_d;

   // Probe k sits on row k/2, column k%2 relative to the centre cell.
   function automatic logic [ADDR_W-1:0] probe_ofs(input logic [CNT_W-1:0] k);
      logic [31:0] row;
      logic [31:0] sum;
      row = 32'(k >> 1);
      sum = row * 32'(IMG_W) + {31'd0, k[0]};
      return sum[ADDR_W-1:0];
   endfunction

   // State and datapath registers.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         addr_q    <= '0;
         pos_q     <= '0;
         hit_q     <= 1'b0;
         out_rdy_q <= 1'b0;
         end_q     <= 1'b0;
         issue_q   <= '0;
         cmp_q     <= '0;
         lat_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         addr_q    <= addr_d;
         pos_q     <= pos_d;
         hit_q     <= hit_d;
         out_rdy_q <= out_rdy_d;
         end_q     <= end_d;
         issue_q   <= issue_d;
         cmp_q     <= cmp_d;
         lat_q     <= lat_d;
      end
   end

   // Next-state logic: address issue runs ahead of the compare by RD_LAT cycles.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      addr_d    = addr_q;
      pos_d     = pos_q;
      hit_d     = hit_q;
      out_rdy_d = 1'b0;
      end_d     = 1'b0;
      issue_d   = issue_q;
      cmp_d     = cmp_q;
      lat_d     = lat_q;
      if (iFinish) begin
         state_d = ST_IDLE;
         base_d  = '0;
         addr_d  = '0;
         pos_d   = '0;
         hit_d   = 1'b0;
         issue_d = '0;
         cmp_d   = '0;
         lat_d   = 2'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (iInput_ready) begin
                  base_d = iPosition;
                  if (iMax_val > MAX_THR) begin
                     addr_d  = iPosition + CTR_OFS_C;
                     issue_d = '0;
                     cmp_d   = '0;
                     lat_d   = 2'd0;
                     state_d = ST_PROBE;
                  end else begin
                     end_d = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PROBE: begin
               if (issue_q < LAST_K) begin
                  issue_d = issue_q + ONE_K;
                  addr_d  = base_q + CTR_OFS_C + probe_ofs(issue_q + ONE_K);
               end else begin
                  issue_d = issue_q;
               end
               if (lat_q < LAT_C) begin
                  lat_d = lat_q + 2'd1;
               end else if (iData_from_OM > OM_THR) begin
                  pos_d     = base_q + probe_ofs(cmp_q);
                  hit_d     = 1'b1;
                  out_rdy_d = 1'b1;
                  state_d   = ST_IDLE;
               end else if (cmp_q == LAST_K) begin
                  pos_d     = base_q;
                  hit_d     = 1'b0;
                  out_rdy_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  cmp_d = cmp_q + ONE_K;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign oAddr_OM      = addr_q;
   assign oReady        = (state_q == ST_IDLE);
   assign oPosition     = pos_q;
   assign oHit          = hit_q;
   assign oOutput_ready = out_rdy_q;
   assign oEnd          = end_q;

`ifdef FACE_CNT_EN
   logic [15:0] face_cnt_q, face_cnt_d;

   // Saturating count of hit results.
   always_comb begin
      face_cnt_d = face_cnt_q;
      if (iFinish) begin
         face_cnt_d = 16'd0;
      end else if (out_rdy_d && hit_d && (face_cnt_q != 16'hFFFF)) begin
         face_cnt_d = face_cnt_q + 16'd1;
      end else begin
         face_cnt_d = face_cnt_q;
      end
   end

   // Hit counter register.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         face_cnt_q <= 16'd0;
      end else begin
         face_cnt_q <= face_cnt_d;
      end
   end

   assign oFace_cnt = face_cnt_q;
`endif

endmodule

// File: tb/tb_face_threshold_probe.sv
// Directed table-driven bench for face_threshold_probe with a 1-cycle-latency OM model.
module tb_face_threshold_probe;

   logic        iClk = 1'b0;
   logic        iReset_n = 1'b0;
   logic        iInput_ready = 1'b0;
   logic [12:0] iPosition = 13'd0;
   logic [31:0] iMax_val = 32'd0;
   logic        iFinish = 1'b0;
   logic [31:0] iData_from_OM;
   logic [12:0] oAddr_OM;
   logic        oReady;
   logic [12:0] oPosition;
   logic        oHit;
   logic        oOutput_ready;
   logic        oEnd;
`ifdef FACE_CNT_EN
   logic [15:0] oFace_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] om_mem [0:8191];

   face_threshold_probe dut (
      .iClk(iClk), .iReset_n(iReset_n), .iInput_ready(iInput_ready),
      .iPosition(iPosition), .iMax_val(iMax_val), .iFinish(iFinish),
      .iData_from_OM(iData_from_OM), .oAddr_OM(oAddr_OM), .oReady(oReady),
      .oPosition(oPosition), .oHit(oHit), .oOutput_ready(oOutput_ready), .oEnd(oEnd)
`ifdef FACE_CNT_EN
      , .oFace_cnt(oFace_cnt)
`endif
   );

   always #5 iClk = ~iClk;

   always @(posedge iClk) iData_from_OM <= om_mem[oAddr_OM];

   typedef struct {
      logic [12:0] pos;
      logic [31:0] maxv;
      logic [31:0] om0, om1, om2, om3;
      bit          acc;
      bit          hit;
      logic [12:0] epos;
      int          lat;
      logic [12:0] eaddr;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [12:0] paddr(input logic [12:0] base, input int k);
      logic [12:0] ofs;
      case (k)
         0: ofs = 13'd0;
         1: ofs = 13'd1;
         2: ofs = 13'd81;
         default: ofs = 13'd82;
      endcase
      return base + 13'd162 + ofs;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int lat = -1;
      int outs = 0;
      int ends = 0;
      om_mem[paddr(v.pos, 0)] = v.om0;
      om_mem[paddr(v.pos, 1)] = v.om1;
      om_mem[paddr(v.pos, 2)] = v.om2;
      om_mem[paddr(v.pos, 3)] = v.om3;
      @(negedge iClk);
      iPosition = v.pos;
      iMax_val = v.maxv;
      iInput_ready = 1'b1;
      for (int n = 0; n <= 8; n++) begin
         @(negedge iClk);
         iInput_ready = 1'b0;
         if (n == 0) begin
            check($sformatf("v%0d ready0", idx), {31'd0, oReady}, {31'd0, !v.acc});
            if (v.acc) check($sformatf("v%0d addr0", idx), {19'd0, oAddr_OM}, {19'd0, paddr(v.pos, 0)});
         end
         if (oOutput_ready) begin
            outs++;
            if (lat < 0) lat = n;
         end
         if (oEnd) ends++;
      end
      check($sformatf("v%0d outs", idx), outs, v.acc ? 32'd1 : 32'd0);
      check($sformatf("v%0d ends", idx), ends, v.acc ? 32'd0 : 32'd1);
      check($sformatf("v%0d lat", idx), lat, v.lat);
      check($sformatf("v%0d pos", idx), {19'd0, oPosition}, {19'd0, v.epos});
      check($sformatf("v%0d hit", idx), {31'd0, oHit}, {31'd0, v.hit});
      check($sformatf("v%0d addr", idx), {19'd0, oAddr_OM}, {19'd0, v.eaddr});
      check($sformatf("v%0d ready", idx), {31'd0, oReady}, 32'd1);
   endtask

   task automatic pulse_finish();
      @(negedge iClk);
      iFinish = 1'b1;
      @(negedge iClk);
      iFinish = 1'b0;
   endtask

   initial begin
      int outs;
      for (int i = 0; i < 8192; i++) om_mem[i] = 32'd0;
      vecs[0] = '{13'd100,  32'h0419999A, 32'h0011EB86, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 13'd100,  2, 13'd343};
      vecs[1] = '{13'd100,  32'h0419999A, 32'd0, 32'd0, 32'h00200000, 32'd0, 1'b1, 1'b1, 13'd181, 4, 13'd344};
      vecs[2] = '{13'd100,  32'h0419999A, 32'h0011EB85, 32'h0011EB85, 32'h0011EB85, 32'h0011EB85, 1'b1, 1'b0, 13'd100, 5, 13'd344};
      vecs[3] = '{13'd500,  32'h04199999, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 13'd100, -1, 13'd344};
      vecs[4] = '{13'd1000, 32'h10000000, 32'd0, 32'h0011EB86, 32'd0, 32'd0, 1'b1, 1'b1, 13'd1001, 3, 13'd1244};
      vecs[5] = '{13'd2000, 32'h10000000, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 13'd2082, 5, 13'd2244};
      vecs[6] = '{13'd8100, 32'h10000000, 32'd0, 32'd0, 32'd0, 32'h01000000, 1'b1, 1'b1, 13'd8182, 5, 13'd152};
      vecs[7] = '{13'd7,    32'h00000000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 13'd8182, -1, 13'd152};
      vecs[8] = '{13'd0,    32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b1, 13'd1, 3, 13'd244};

      #12;
      check("rst ready", {31'd0, oReady}, 32'd1);
      check("rst addr", {19'd0, oAddr_OM}, 32'd0);
      check("rst outs", {29'd0, oOutput_ready, oEnd, oHit}, 32'd0);
      iReset_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // iFinish mid-probe on the wrapped window aborts without a result.
      om_mem[70] = 32'hFFFFFFFF;
      @(negedge iClk);
      iPosition = 13'd8100;
      iMax_val = 32'h10000000;
      iInput_ready = 1'b1;
      @(negedge iClk);
      iInput_ready = 1'b0;
      check("wrap addr0", {19'd0, oAddr_OM}, 32'd70);
      @(negedge iClk);
      check("wrap addr1", {19'd0, oAddr_OM}, 32'd71);
      iFinish = 1'b1;
      @(negedge iClk);
      iFinish = 1'b0;
      outs = 0;
      if (oOutput_ready) outs++;
      check("fin ready", {31'd0, oReady}, 32'd1);
      check("fin addr", {19'd0, oAddr_OM}, 32'd0);
      check("fin pos", {19'd0, oPosition}, 32'd0);
      check("fin hit", {31'd0, oHit}, 32'd0);
      for (int n = 0; n < 6; n++) begin
         @(negedge iClk);
         if (oOutput_ready) outs++;
      end
      check("fin nopulse", outs, 32'd0);

      // iFinish wins over a simultaneous candidate.
      @(negedge iClk);
      iPosition = 13'd100;
      iMax_val = 32'h10000000;
      iInput_ready = 1'b1;
      iFinish = 1'b1;
      @(negedge iClk);
      iInput_ready = 1'b0;
      iFinish = 1'b0;
      check("fin+in ready", {31'd0, oReady}, 32'd1);
      check("fin+in addr", {19'd0, oAddr_OM}, 32'd0);

`ifdef FACE_CNT_EN
      pulse_finish();
      run_vec(vecs[0], 10);
      run_vec(vecs[1], 11);
      run_vec(vecs[2], 12);
      run_vec(vecs[4], 13);
      check("cnt three", {16'd0, oFace_cnt}, 32'd3);
      pulse_finish();
      check("cnt clear", {16'd0, oFace_cnt}, 32'd0);
`endif

      // Asynchronous reset while probing.
      @(negedge iClk);
      iPosition = 13'd100;
      iMax_val = 32'h10000000;
      iInput_ready = 1'b1;
      @(negedge iClk);
      iInput_ready = 1'b0;
      check("pre-rst ready", {31'd0, oReady}, 32'd0);
      #2;
      iReset_n = 1'b0;
      #1;
      check("arst ready", {31'd0, oReady}, 32'd1);
      check("arst addr", {19'd0, oAddr_OM}, 32'd0);
      check("arst outs", {16'd0, oPosition, oOutput_ready, oEnd, oHit}, 32'd0);
      @(negedge iClk);
      iReset_n = 1'b1;
      @(negedge iClk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
